seq_wide_adder_ctrl: RTL and testbench
======================================

Name: seq_wide_adder_ctrl

Overview:
Multi-cycle controller that performs a W-bit signed/unsigned addition by sequencing one N-bit chunk adder (ripple-carry slice) over W/N cycles, chaining the carry between chunks.
It is the sequencer that lets the ALU trade adder area for latency.
It has a start/ready/done handshake, and reports signed overflow and unsigned carry exactly as the full-width adder would.

Parameters:
W, 32, total operand width in bits; must be a multiple of N.
N, 8, chunk adder width in bits; N >= 1. W == N is legal and gives a single-chunk run.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a new addition; sampled only while ready = 1
ready  output  1  high in IDLE; the controller can accept start
X  input  W  operand A (two's complement); sampled on the accepting edge
Y  input  W  operand B (two's complement); sampled on the accepting edge
done  output  1  one-cycle pulse; Z, overflow and carry_out are valid and updated
Z  output  W  sum X+Y modulo 2^W; held until the next completion
overflow  output  1  signed overflow of the last completed addition
carry_out  output  1  unsigned carry out of bit W-1 of the last completed addition
busy  output  1  high in RUN and DONE

Behaviour:
- Reset (rst = 1 at a clk edge):
  - state goes to IDLE
  - ready = 1, done = 0, busy = 0
  - Z = 0, overflow = 0, carry_out = 0
  - internal operand, partial-sum, carry and chunk-index registers all cleared
- Reset has priority over everything else, including mid-RUN. An aborted run never produces done, and the old Z is not preserved.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready = 1
  - start = 1 at an edge latches X and Y, sets idx = 0 and carry = 0, and goes to RUN
  - start = 0 stays in IDLE
- RUN:
  - ready = 0, busy = 1
  - each edge computes chunk idx: {c, s} = Xr[idx*N +: N] + Yr[idx*N +: N] + carry
  - s is written into the partial-sum register at idx, carry <= c, idx <= idx + 1
  - the edge that processes chunk W/N-1 goes to DONE and, on that same edge, loads:
    - Z <= full partial sum including the last chunk
    - carry_out <= c
    - overflow <= (carry into bit W-1) XOR (carry out of bit W-1), computed inside the last chunk
- DONE:
  - done = 1 and busy = 1 for exactly one cycle
  - next edge goes to IDLE unconditionally
- Latency: start accepted at edge k; done is high in the cycle following edge k + W/N. With the defaults, done is high W/N = 4 cycles after the accepting edge.
- Throughput: one addition per W/N + 2 cycles.
- start while ready = 0 (RUN or DONE) is ignored and not queued. The in-flight operands are unaffected by X/Y changes after acceptance.
- Z, overflow and carry_out change only on the edge that enters DONE, or on reset. They are stable in all other cycles.
- Arithmetic is identical to a W-bit ripple-carry adder with carry-in 0:
  - Z == (X + Y) mod 2^W
  - overflow = 1 iff X and Y have the same sign and Z's sign differs

Optional Feature:
Macro SEQ_ADDER_SUB_EN.
- Defined:
  - adds input port sub (1 bit), latched together with X and Y on the accepting edge
  - sub = 1 computes X - Y: Yr is stored as ~Y and the initial carry is 1
  - overflow = carry into bit W-1 XOR carry out of bit W-1
  - carry_out = raw carry out (1 means no borrow)
  - sub = 0 behaves exactly as the base block
- Not defined: the port sub does not exist and the block only adds.

Test Plan:
1. rst for 2 cycles, then X=0, Y=0, start for 1 cycle.
   -> ready drops the next cycle; done pulses exactly 4 cycles after acceptance; Z=0, overflow=0, carry_out=0; ready returns the cycle after done.
2. X=32'h7FFFFFFF, Y=1.
   -> Z=32'h80000000, overflow=1, carry_out=0.
   Then X=32'hFFFFFFFF, Y=1.
   -> Z=0, overflow=0, carry_out=1.
3. X=32'h80000000, Y=32'h80000000.
   -> Z=0, overflow=1, carry_out=1.
   Then X=-2, Y=-2.
   -> Z=32'hFFFFFFFC, overflow=0, carry_out=1.
4. Accept X=5, Y=7, then pulse start with X=100, Y=100 and change X/Y every cycle during RUN.
   -> exactly one done; Z=12; no second done follows.
5. Accept X=10, Y=20; after the complete run Z=30. Start X=1, Y=1 and assert rst on the 2nd RUN edge.
   -> state IDLE, ready=1, Z=0, no done pulse. A following X=3, Y=4 gives Z=7 with normal latency.
6. Random sweep of 1000 vectors at W=3, N=1, plus default W/N, with SEQ_ADDER_SUB_EN defined and sub random.
   -> Z, overflow and carry_out match the golden model (X±Y, sign-rule overflow); error count = 0.

Source files
------------

// File: rtl/seq_wide_adder_ctrl.sv
// seq_wide_adder_ctrl
// Multi-cycle W-bit adder built from a single N-bit ripple-carry slice. The
// slice is sequenced over W/N chunks, least significant first, and the carry
// is chained between chunks. The result is bit-identical to a full-width
// adder with carry-in 0, including the signed overflow and unsigned carry
// flags.
//
// Optional feature macro: SEQ_ADDER_SUB_EN
//   When defined, the input 'sub' is added. With sub = 1 the operation is
//   X - Y, computed as X + ~Y + 1. In that case carry_out = 1 means no borrow.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (priority over everything)
//   start     request a new operation; only sampled while ready = 1
//   sub       (SEQ_ADDER_SUB_EN only) 1 = subtract, latched with X/Y
//   X, Y      W-bit operands, latched on the accepting edge
//   ready     high in IDLE
//   done      one-cycle pulse when Z/overflow/carry_out are updated
//   Z         W-bit result, held until the next completion
//   overflow  signed overflow of the last completed operation
//   carry_out carry out of bit W-1 of the last completed operation
//   busy      high in RUN and DONE
module seq_wide_adder_ctrl #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef SEQ_ADDER_SUB_EN
  input  logic         sub,
`endif
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] Z,
  output logic         overflow,
  output logic         carry_out,
  output logic         busy
);

  localparam int NCH = W / N;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_xr;
  logic [W-1:0]    r_yr;
  logic [W-1:0]    r_psum;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic            r_ready;
  logic            r_done;
  logic            r_busy;
  logic [W-1:0]    r_z;
  logic            r_ovf;
  logic            r_cout;

  logic [N-1:0]    w_xc;
  logic [N-1:0]    w_yc;
  logic [N:0]      w_sum;
  logic            w_carryIntoMsb;
  logic            w_ovf;
  logic            w_lastChunk;
  logic [W-1:0]    w_psumNext;
  logic            w_subSel;

`ifdef SEQ_ADDER_SUB_EN
  assign w_subSel = sub;
`else
  assign w_subSel = 1'b0;
`endif

  // One N-bit slice of the wide adder, selected by the chunk index.
  // The carry into the chunk MSB is recovered as a ^ b ^ sum at that bit.
  // This also holds when N == 1, where that carry is simply r_carry.
  always_comb begin
    w_xc           = r_xr[r_idx*N +: N];
    w_yc           = r_yr[r_idx*N +: N];
    w_sum          = {1'b0, w_xc} + {1'b0, w_yc} + {{N{1'b0}}, r_carry};
    w_carryIntoMsb = w_xc[N-1] ^ w_yc[N-1] ^ w_sum[N-1];
    w_ovf          = w_carryIntoMsb ^ w_sum[N];
    w_lastChunk    = (r_idx == IW'(NCH - 1));
    w_psumNext     = r_psum;
    w_psumNext[r_idx*N +: N] = w_sum[N-1:0];
  end

  // Controller FSM with registered handshake and result outputs. Results are
  // loaded only on the edge that enters DONE, so they stay stable otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_xr    <= '0;
      r_yr    <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_z     <= '0;
      r_ovf   <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtraction is X + ~Y + 1: invert Y and seed the carry with 1.
            r_xr    <= X;
            r_yr    <= w_subSel ? ~Y : Y;
            r_carry <= w_subSel;
            r_idx   <= '0;
            r_state <= RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_psum  <= w_psumNext;
          r_carry <= w_sum[N];
          r_idx   <= r_idx + 1'b1;
          if (w_lastChunk) begin
            r_z     <= w_psumNext;
            r_cout  <= w_sum[N];
            r_ovf   <= w_ovf;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign busy      = r_busy;
  assign Z         = r_z;
  assign overflow  = r_ovf;
  assign carry_out = r_cout;

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// tb_seq_wide_adder_ctrl
// Directed and random checks of seq_wide_adder_ctrl.
// Two instances are used: the default W=32/N=8 instance and a W=3/N=1
// instance for an exhaustive-ish random sweep.
// Expected results come from a behavioural model of the full-width operation.
// They are queued when an operation is launched and compared when done pulses.
module tb_seq_wide_adder_ctrl;

  localparam int W    = 32;
  localparam int N    = 8;
  localparam int NCH  = W / N;
  localparam int SW   = 3;
  localparam int SN   = 1;
  localparam int SNCH = SW / SN;

  typedef struct packed {
    logic [W-1:0] z;
    logic         ov;
    logic         co;
  } exp_t;

  typedef struct packed {
    logic [SW-1:0] z;
    logic          ov;
    logic          co;
  } sexp_t;

  logic clk = 1'b0;
  logic rst;

  logic         start, subIn, ready, done, overflow, carryOut, busy;
  logic [W-1:0] xIn, yIn, zOut;

  logic          sStart, sSub, sReady, sDone, sOverflow, sCarryOut, sBusy;
  logic [SW-1:0] sX, sY, sZ;

  exp_t  sbq[$];
  sexp_t ssbq[$];
  int    checkCount = 0;
  int    passCount  = 0;

  // Free-running clock shared by both instances
  always #5 clk = ~clk;

  seq_wide_adder_ctrl #(.W(W), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef SEQ_ADDER_SUB_EN
    .sub(subIn),
`endif
    .X(xIn),
    .Y(yIn),
    .ready(ready),
    .done(done),
    .Z(zOut),
    .overflow(overflow),
    .carry_out(carryOut),
    .busy(busy)
  );

  seq_wide_adder_ctrl #(.W(SW), .N(SN)) dutSmall (
    .clk(clk),
    .rst(rst),
    .start(sStart),
`ifdef SEQ_ADDER_SUB_EN
    .sub(sSub),
`endif
    .X(sX),
    .Y(sY),
    .ready(sReady),
    .done(sDone),
    .Z(sZ),
    .overflow(sOverflow),
    .carry_out(sCarryOut),
    .busy(sBusy)
  );

  // Golden models: full-width sum with sign-rule overflow
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0] full;
    logic [W-1:0] bb;
    exp_t e;
    bb = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
    e.z  = full[W-1:0];
    e.co = full[W];
    if (s) e.ov = (a[W-1] != b[W-1]) && (e.z[W-1] != a[W-1]);
    else   e.ov = (a[W-1] == b[W-1]) && (e.z[W-1] != a[W-1]);
    return e;
  endfunction

  function automatic sexp_t smallModel(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic s);
    logic [SW:0] full;
    logic [SW-1:0] bb;
    sexp_t e;
    bb = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (SW+1)'(s);
    e.z  = full[SW-1:0];
    e.co = full[SW];
    if (s) e.ov = (a[SW-1] != b[SW-1]) && (e.z[SW-1] != a[SW-1]);
    else   e.ov = (a[SW-1] == b[SW-1]) && (e.z[SW-1] != a[SW-1]);
    return e;
  endfunction

  // One comparison: counts it and reports observed vs expected on mismatch
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic randSub();
`ifdef SEQ_ADDER_SUB_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // Launch one operation on the wide instance and check the full handshake
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int   n;
    exp_t e;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("readyBeforeStart", 64'(ready), 64'd1);
    xIn = a; yIn = b; subIn = s; start = 1'b1;
    sbq.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b0;
    checkOutput("readyDrop", 64'(ready), 64'd0);
    checkOutput("busyRun", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency", 64'(n), 64'(NCH));
    e = sbq.pop_front();
    if (done) begin
      checkOutput("Z", 64'(zOut), 64'(e.z));
      checkOutput("overflow", 64'(overflow), 64'(e.ov));
      checkOutput("carryOut", 64'(carryOut), 64'(e.co));
      checkOutput("busyDone", 64'(busy), 64'd1);
    end
    @(negedge clk);
    checkOutput("doneOnePulse", 64'(done), 64'd0);
    checkOutput("readyAfterDone", 64'(ready), 64'd1);
  endtask

  // Launch one operation on the narrow instance and check its result
  task automatic runSmall(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic s);
    int    n;
    sexp_t e;
    n = 0;
    while (!sReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    sX = a; sY = b; sSub = s; sStart = 1'b1;
    ssbq.push_back(smallModel(a, b, s));
    @(negedge clk);
    sStart = 1'b0;
    n = 0;
    while (!sDone && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("smallLatency", 64'(n), 64'(SNCH));
    e = ssbq.pop_front();
    if (sDone) begin
      checkOutput("smallZ", 64'(sZ), 64'(e.z));
      checkOutput("smallOverflow", 64'(sOverflow), 64'(e.ov));
      checkOutput("smallCarryOut", 64'(sCarryOut), 64'(e.co));
    end
    @(negedge clk);
  endtask

  // Directed sequence followed by random sweeps
  initial begin
    int doneCount;
    exp_t e;
    rst = 1'b1; start = 1'b0; subIn = 1'b0; xIn = '0; yIn = '0;
    sStart = 1'b0; sSub = 1'b0; sX = '0; sY = '0;

    $display("[TB] reset");
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstReady", 64'(ready), 64'd1);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstZ", 64'(zOut), 64'd0);
    checkOutput("rstOverflow", 64'(overflow), 64'd0);
    checkOutput("rstCarryOut", 64'(carryOut), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed additions");
    applyStimulus(32'd0, 32'd0, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'd1, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'd1, 1'b0);
    applyStimulus(32'h80000000, 32'h80000000, 1'b0);
    applyStimulus(32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0);

    $display("[TB] start ignored while busy, operands isolated");
    checkOutput("readyT4", 64'(ready), 64'd1);
    xIn = 32'd5; yIn = 32'd7; subIn = 1'b0; start = 1'b1;
    sbq.push_back(model(32'd5, 32'd7, 1'b0));
    @(negedge clk);
    xIn = 32'd100; yIn = 32'd100; start = 1'b1;
    doneCount = 0;
    for (int i = 0; i < NCH + 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      xIn = $urandom;
      yIn = $urandom;
      if (done) begin
        doneCount++;
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          checkOutput("isolatedZ", 64'(zOut), 64'(e.z));
        end
      end
    end
    checkOutput("singleDone", 64'(doneCount), 64'd1);
    sbq.delete();

    $display("[TB] reset during run");
    applyStimulus(32'd10, 32'd20, 1'b0);
    xIn = 32'd1; yIn = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortReady", 64'(ready), 64'd1);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortZ", 64'(zOut), 64'd0);
    doneCount = 0;
    for (int i = 0; i < NCH + 4; i++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abortNoDone", 64'(doneCount), 64'd0);
    applyStimulus(32'd3, 32'd4, 1'b0);

`ifdef SEQ_ADDER_SUB_EN
    $display("[TB] directed subtraction");
    applyStimulus(32'd5, 32'd7, 1'b1);
    applyStimulus(32'h80000000, 32'd1, 1'b1);
`endif

    $display("[TB] random sweep, wide instance");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(32'($urandom), 32'($urandom), randSub());
    end

    $display("[TB] random sweep, W=3 N=1 instance");
    for (int i = 0; i < 1000; i++) begin
      runSmall(3'($urandom), 3'($urandom), randSub());
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
